// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 DIT FFT stage sequencer.
// Optional bit-reversal pre-pass enabled by defining FFT_BITREV_LOAD_EN.

`ifndef FFT_PKG_MACROS
`define FFT_PKG_MACROS
// Complex word layout is {re, im}, each dw bits wide
`define FFT_CPLX_RE(w, dw) w[2*(dw)-1:(dw)]
`define FFT_CPLX_IM(w, dw) w[(dw)-1:0]
`define FFT_CPLX_PACK(re, im) {re, im}
`endif

package fft_pkg;

    localparam int unsigned FFT_LOG2N     = 8;
    localparam int unsigned FFT_N         = 1 << FFT_LOG2N;
    localparam int unsigned FFT_DATA_W    = 32;
    localparam int unsigned FFT_MAX_LOG2N = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_BF_GO,
        S_BF_ACK,
        S_BF_WAIT,
        S_WR,
        S_NEXT,
        S_DONE
`ifdef FFT_BITREV_LOAD_EN
        ,
        S_BR_RD,
        S_BR_WAIT,
        S_BR_WR
`endif
    } state_t;

    // Reverse the low 'bits' bits of v; bits above 'bits' come back zero
    function automatic logic [FFT_MAX_LOG2N-1:0] bitrev(
        input logic [FFT_MAX_LOG2N-1:0] v,
        input int unsigned              bits
    );
        logic [FFT_MAX_LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FFT_MAX_LOG2N; i++) begin
            if (i < bits) begin
                r[4'(bits - 1 - i)] = v[4'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address pair and twiddle index for stage s, butterfly k.

module fft_addr_gen #(
    parameter int unsigned LOG2N = 8,
    parameter int unsigned SW    = 3
) (
    input  logic [SW-1:0]    s_i,
    input  logic [LOG2N-2:0] k_i,
    output logic [LOG2N-1:0] i0_o,
    output logic [LOG2N-1:0] i1_o,
    output logic [LOG2N-2:0] tw_o
);

    localparam int unsigned KW = LOG2N - 1;

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;

    // Insert a zero at bit s of k for the top point; bottom point sets that bit
    always_comb begin
        k_ext = LOG2N'(k_i);
        half  = LOG2N'(1) << s_i;
        pos   = k_ext & (half - LOG2N'(1));
        i0_o  = ((k_ext >> s_i) << (32'(s_i) + 32'd1)) | pos;
        i1_o  = i0_o | half;
        tw_o  = KW'(pos << (32'(KW) - 32'(s_i)));
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequencer driving a radix-2 butterfly over a dual-port sample RAM, in place.
// Define FFT_BITREV_LOAD_EN to add a bit-reversal permutation pre-pass.

module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N  = FFT_LOG2N,
    parameter int unsigned DATA_W = FFT_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [LOG2N-1:0]    a_addr,
    output logic                a_we,
    output logic [2*DATA_W-1:0] a_wdata,
    input  logic [2*DATA_W-1:0] a_rdata,
    output logic [LOG2N-1:0]    b_addr,
    output logic                b_we,
    output logic [2*DATA_W-1:0] b_wdata,
    input  logic [2*DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0]   bf_r1,
    output logic [DATA_W-1:0]   bf_i1,
    output logic [DATA_W-1:0]   bf_r2,
    output logic [DATA_W-1:0]   bf_i2,
    output logic [LOG2N-2:0]    bf_tw,
    output logic                bf_start,
    input  logic                bf_ready,
    input  logic                bf_valid,
    input  logic [DATA_W-1:0]   bf_nr1,
    input  logic [DATA_W-1:0]   bf_ni1,
    input  logic [DATA_W-1:0]   bf_nr2,
    input  logic [DATA_W-1:0]   bf_ni2
);

    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    state_t        state_q;
    logic [SW-1:0] s_q;
    logic [KW-1:0] k_q;

    logic          last_k_c;
    logic          last_s_c;
    logic [SW-1:0] ag_s_c;
    logic [KW-1:0] ag_k_c;
    logic [LOG2N-1:0] ag_i0_c;
    logic [LOG2N-1:0] ag_i1_c;
    logic [KW-1:0]    ag_tw_c;

    assign last_k_c = (k_q == {KW{1'b1}});
    assign last_s_c = (s_q == SW'(LOG2N - 1));

    // Address generator looks one step ahead while in NEXT so RD sees the new pair
    always_comb begin
        ag_s_c = s_q;
        ag_k_c = k_q;
        if (state_q == S_NEXT) begin
            ag_k_c = k_q + KW'(1);
            if (last_k_c) begin
                ag_s_c = s_q + SW'(1);
            end
        end
    end

    fft_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .s_i  (ag_s_c),
        .k_i  (ag_k_c),
        .i0_o (ag_i0_c),
        .i1_o (ag_i1_c),
        .tw_o (ag_tw_c)
    );

`ifdef FFT_BITREV_LOAD_EN
    logic [LOG2N-1:0] j_q;
    logic [LOG2N-1:0] j_nxt_c;
    logic [LOG2N-1:0] rev_j_c;
    logic [LOG2N-1:0] rev_jn_c;
    logic             last_j_c;

    assign j_nxt_c  = j_q + LOG2N'(1);
    assign rev_j_c  = LOG2N'(bitrev(FFT_MAX_LOG2N'(j_q), LOG2N));
    assign rev_jn_c = LOG2N'(bitrev(FFT_MAX_LOG2N'(j_nxt_c), LOG2N));
    assign last_j_c = (j_q == {LOG2N{1'b1}});
`endif

    // Control FSM with registered RAM/butterfly outputs; pulses default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s_q      <= '0;
            k_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_addr   <= '0;
            a_we     <= 1'b0;
            a_wdata  <= '0;
            b_addr   <= '0;
            b_we     <= 1'b0;
            b_wdata  <= '0;
            bf_r1    <= '0;
            bf_i1    <= '0;
            bf_r2    <= '0;
            bf_i2    <= '0;
            bf_tw    <= '0;
            bf_start <= 1'b0;
`ifdef FFT_BITREV_LOAD_EN
            j_q      <= '0;
`endif
        end else begin
            bf_start <= 1'b0;
            done     <= 1'b0;
            a_we     <= 1'b0;
            b_we     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef FFT_BITREV_LOAD_EN
                        j_q     <= '0;
                        a_addr  <= '0;
                        b_addr  <= '0;
                        state_q <= S_BR_RD;
`else
                        a_addr  <= ag_i0_c;
                        b_addr  <= ag_i1_c;
                        bf_tw   <= ag_tw_c;
                        state_q <= S_RD;
`endif
                    end
                end
`ifdef FFT_BITREV_LOAD_EN
                S_BR_RD: begin
                    if (rev_j_c > j_q) begin
                        state_q <= S_BR_WAIT;
                    end else if (last_j_c) begin
                        a_addr  <= ag_i0_c;
                        b_addr  <= ag_i1_c;
                        bf_tw   <= ag_tw_c;
                        state_q <= S_RD;
                    end else begin
                        j_q    <= j_nxt_c;
                        a_addr <= j_nxt_c;
                        b_addr <= rev_jn_c;
                    end
                end
                S_BR_WAIT: begin
                    a_wdata <= b_rdata;
                    b_wdata <= a_rdata;
                    a_we    <= 1'b1;
                    b_we    <= 1'b1;
                    state_q <= S_BR_WR;
                end
                S_BR_WR: begin
                    if (last_j_c) begin
                        a_addr  <= ag_i0_c;
                        b_addr  <= ag_i1_c;
                        bf_tw   <= ag_tw_c;
                        state_q <= S_RD;
                    end else begin
                        j_q     <= j_nxt_c;
                        a_addr  <= j_nxt_c;
                        b_addr  <= rev_jn_c;
                        state_q <= S_BR_RD;
                    end
                end
`endif
                S_RD: begin
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    bf_r1   <= `FFT_CPLX_RE(a_rdata, DATA_W);
                    bf_i1   <= `FFT_CPLX_IM(a_rdata, DATA_W);
                    bf_r2   <= `FFT_CPLX_RE(b_rdata, DATA_W);
                    bf_i2   <= `FFT_CPLX_IM(b_rdata, DATA_W);
                    state_q <= S_BF_GO;
                end
                S_BF_GO: begin
                    if (bf_ready) begin
                        bf_start <= 1'b1;
                        state_q  <= S_BF_ACK;
                    end
                end
                S_BF_ACK: begin
                    state_q <= S_BF_WAIT;
                end
                S_BF_WAIT: begin
                    if (bf_valid) begin
                        a_wdata <= `FFT_CPLX_PACK(bf_nr1, bf_ni1);
                        b_wdata <= `FFT_CPLX_PACK(bf_nr2, bf_ni2);
                        a_we    <= 1'b1;
                        b_we    <= 1'b1;
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_k_c && last_s_c) begin
                        s_q     <= '0;
                        k_q     <= '0;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        s_q     <= ag_s_c;
                        k_q     <= ag_k_c;
                        a_addr  <= ag_i0_c;
                        b_addr  <= ag_i1_c;
                        bf_tw   <= ag_tw_c;
                        state_q <= S_RD;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at LOG2N=3 with RAM and butterfly models.

module tb_fft_stage_sequencer;

    localparam int unsigned LOG2N = 3;
    localparam int unsigned N     = 8;
    localparam int unsigned NBF   = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned KW    = LOG2N - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy, done;
    logic [LOG2N-1:0] a_addr, b_addr;
    logic             a_we, b_we;
    logic [2*DW-1:0]  a_wdata, b_wdata;
    logic [2*DW-1:0]  a_rdata, b_rdata;
    logic [DW-1:0]    bf_r1, bf_i1, bf_r2, bf_i2;
    logic [KW-1:0]    bf_tw;
    logic             bf_start;
    logic             bf_ready;
    logic             bf_valid = 1'b0;
    logic [DW-1:0]    bf_nr1, bf_ni1, bf_nr2, bf_ni2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    fft_stage_sequencer #(.LOG2N(LOG2N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata), .b_rdata(b_rdata),
        .bf_r1(bf_r1), .bf_i1(bf_i1), .bf_r2(bf_r2), .bf_i2(bf_i2),
        .bf_tw(bf_tw), .bf_start(bf_start), .bf_ready(bf_ready), .bf_valid(bf_valid),
        .bf_nr1(bf_nr1), .bf_ni1(bf_ni1), .bf_nr2(bf_nr2), .bf_ni2(bf_ni2)
    );

    always #5 clk = ~clk;

    // ---------------- dual-port RAM, 1-cycle read latency ----------------
    logic [2*DW-1:0]  mem [N];
    logic             ld_en = 1'b0;
    logic [LOG2N-1:0] ld_addr = '0;
    logic [2*DW-1:0]  ld_data = '0;

    always @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
        if (ld_en) mem[ld_addr] <= ld_data;
        if (a_we)  mem[a_addr]  <= a_wdata;
        if (b_we)  mem[b_addr]  <= b_wdata;
    end

    // ---------------- butterfly stand-in: x1 +/- x2*(tw+1) ----------------
    function automatic void bfly(input logic [31:0] r1, i1, r2, i2, input int unsigned tw,
                                 output logic [31:0] nr1, ni1, nr2, ni2);
        logic [31:0] w;
        w   = 32'(tw) + 32'd1;
        nr1 = r1 + r2 * w;
        ni1 = i1 + i2 * w;
        nr2 = r1 - r2 * w;
        ni2 = i1 - i2 * w;
    endfunction

    int unsigned m_lat_fixed = 0;
    int unsigned m_cnt = 0;
    int unsigned m_gap = 0;
    logic        m_busy = 1'b0;
    logic [31:0] m_r1, m_i1, m_r2, m_i2;
    logic [KW-1:0] m_tw;
    logic [31:0] t1, t2, t3, t4;
    int unsigned proto_err = 0;

    assign bf_ready = !m_busy && (m_gap == 0);

    always @(posedge clk) begin
        if (bf_start) begin
            if (!bf_ready) proto_err <= proto_err + 1;
            m_busy   <= 1'b1;
            m_cnt    <= (m_lat_fixed != 0) ? m_lat_fixed : $urandom_range(1, 6);
            bf_valid <= 1'b0;
            m_r1 <= bf_r1; m_i1 <= bf_i1; m_r2 <= bf_r2; m_i2 <= bf_i2; m_tw <= bf_tw;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                bfly(m_r1, m_i1, m_r2, m_i2, int'(m_tw), t1, t2, t3, t4);
                bf_nr1 <= t1; bf_ni1 <= t2; bf_nr2 <= t3; bf_ni2 <= t4;
                bf_valid <= 1'b1;
                m_busy   <= 1'b0;
                m_gap    <= (m_lat_fixed != 0) ? 0 : $urandom_range(0, 7);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_gap != 0) begin
            m_gap <= m_gap - 1;
        end
    end

    // ---------------- event monitor (monotonic counters) ----------------
    int unsigned bf_cnt = 0, done_cnt = 0, wr_cnt = 0, main_wr = 0, stale_wr = 0;
    logic        armed = 1'b0, fresh = 1'b0;
    logic [LOG2N-1:0] tr_i0 [256];
    logic [LOG2N-1:0] tr_i1 [256];
    logic [KW-1:0]    tr_tw [256];

    always @(posedge clk) begin
        if (bf_start) begin
            tr_i0[bf_cnt[7:0]] <= a_addr;
            tr_i1[bf_cnt[7:0]] <= b_addr;
            tr_tw[bf_cnt[7:0]] <= bf_tw;
            bf_cnt <= bf_cnt + 1;
            armed  <= 1'b1;
            fresh  <= 1'b0;
        end else if (armed && bf_valid) begin
            fresh <= 1'b1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (a_we || b_we) begin
            wr_cnt <= wr_cnt + 1;
            if (armed) begin
                if (!fresh) stale_wr <= stale_wr + 1;
                main_wr <= main_wr + 1;
                armed   <= 1'b0;
            end
        end
        if (rst) armed <= 1'b0;
    end

    // ---------------- reference model ----------------
    logic [2*DW-1:0] init_mem [N];
    logic [2*DW-1:0] exp_mem  [N];
    logic [2*DW-1:0] snap_mem [N];

    function automatic int unsigned rev_idx(input int unsigned j);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < LOG2N; b++)
            if (((j >> b) & 1) != 0) r = r + (1 << (LOG2N - 1 - b));
        return r;
    endfunction

    task automatic ref_fft();
        int unsigned half, pos, i0, i1, tw;
        logic [31:0] o1, o2, o3, o4;
        for (int unsigned j = 0; j < N; j++) exp_mem[j] = init_mem[j];
`ifdef FFT_BITREV_LOAD_EN
        for (int unsigned j = 0; j < N; j++) exp_mem[j] = init_mem[rev_idx(j)];
`endif
        for (int unsigned s = 0; s < LOG2N; s++) begin
            for (int unsigned k = 0; k < N / 2; k++) begin
                half = 1 << s;
                pos  = k % half;
                i0   = (k / half) * (2 * half) + pos;
                i1   = i0 + half;
                tw   = pos * (N / (2 * half));
                bfly(exp_mem[i0][63:32], exp_mem[i0][31:0], exp_mem[i1][63:32], exp_mem[i1][31:0],
                     tw, o1, o2, o3, o4);
                exp_mem[i0] = {o1, o2};
                exp_mem[i1] = {o3, o4};
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_ram(input int unsigned mode);
        for (int unsigned i = 0; i < N; i++) begin
            case (mode)
                0: init_mem[i] = {$urandom, $urandom};
                1: init_mem[i] = (i == 0) ? {32'h3F800000, 32'h0} : 64'h0;
                default: init_mem[i] = {32'(i), 32'h0};
            endcase
            @(negedge clk);
            ld_en = 1'b1; ld_addr = LOG2N'(i); ld_data = init_mem[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_fft(input int unsigned budget, output bit timed_out);
        int unsigned d0;
        bit snapped;
        d0 = done_cnt;
        snapped = 1'b0;
        timed_out = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int unsigned c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bf_start && !snapped) begin
                for (int unsigned i = 0; i < N; i++) snap_mem[i] = mem[i];
                snapped = 1'b1;
            end
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        #1;
        checks++;
        if ({busy, done, a_we, b_we, bf_start} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b expected 00000", {busy, done, a_we, b_we, bf_start});
        end
        checks++;
        if ({a_addr, b_addr, bf_tw} !== '0) begin
            errors++; $display("FAIL reset_addr got %h expected 0", {a_addr, b_addr, bf_tw});
        end
        checks++;
        if ({a_wdata, b_wdata, bf_r1, bf_i1, bf_r2, bf_i2} !== '0) begin
            errors++; $display("FAIL reset_data got nonzero data expected 0");
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_cnt != 0) begin
            errors++; $display("FAIL reset_idle busy=%b writes=%0d expected 0/0", busy, wr_cnt);
        end
    endtask

    task automatic test_impulse();
        bit to;
        int unsigned w0;
        load_ram(1);
        w0 = main_wr;
        run_fft(3000, to);
        checks++;
        if (to) begin errors++; $display("FAIL impulse_timeout no done within budget"); end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== {32'h3F800000, 32'h0}) begin
                errors++; $display("FAIL impulse_ram[%0d] got %h expected 3f80000000000000", i, mem[i]);
            end
        end
        checks++;
        if (main_wr - w0 != NBF) begin
            errors++; $display("FAIL impulse_writes got %0d expected %0d", main_wr - w0, NBF);
        end
    endtask

    task automatic test_stale_valid();
        bit to;
        int unsigned sw0;
        checks++;
        if (bf_valid !== 1'b1) begin
            errors++; $display("FAIL stale_pre bf_valid got %b expected 1", bf_valid);
        end
        load_ram(0);
        ref_fft();
        sw0 = stale_wr;
        run_fft(3000, to);
        checks++;
        if (to || stale_wr != sw0) begin
            errors++; $display("FAIL stale_write timeout=%0d stale_writes=%0d expected 0/0", to, stale_wr - sw0);
        end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++; $display("FAIL stale_ram[%0d] got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_trace();
        bit to;
        int unsigned b0, p0;
        int exp_t [12][3];
        exp_t = '{'{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
                  '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
                  '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};
        m_lat_fixed = 4;
        load_ram(0);
        ref_fft();
        b0 = bf_cnt;
        p0 = proto_err;
        run_fft(3000, to);
        checks++;
        if (to || bf_cnt - b0 != NBF) begin
            errors++; $display("FAIL trace_count timeout=%0d butterflies=%0d expected %0d", to, bf_cnt - b0, NBF);
        end
        for (int unsigned i = 0; i < NBF; i++) begin
            checks++;
            if (int'(tr_i0[8'(b0 + i)]) != exp_t[i][0] || int'(tr_i1[8'(b0 + i)]) != exp_t[i][1] ||
                int'(tr_tw[8'(b0 + i)]) != exp_t[i][2]) begin
                errors++;
                $display("FAIL trace[%0d] got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i,
                         tr_i0[8'(b0 + i)], tr_i1[8'(b0 + i)], tr_tw[8'(b0 + i)],
                         exp_t[i][0], exp_t[i][1], exp_t[i][2]);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++; $display("FAIL trace_ram[%0d] got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
        checks++;
        if (proto_err != p0) begin
            errors++; $display("FAIL trace_proto start_without_ready=%0d expected 0", proto_err - p0);
        end
        m_lat_fixed = 0;
    endtask

    task automatic test_start_ignored();
        int unsigned d0, w0, b0, p0;
        bit seen, busy_seen;
        load_ram(0);
        ref_fft();
        d0 = done_cnt; w0 = main_wr; b0 = bf_cnt; p0 = proto_err;
        seen = 1'b0; busy_seen = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int unsigned c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (done) begin
                start = 1'b1;
                seen  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                break;
            end
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (!seen || !busy_seen) begin
            errors++; $display("FAIL ignore_timeout done_seen=%0d busy_seen=%0d expected 1/1", seen, busy_seen);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL ignore_done_pulses got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (main_wr - w0 != NBF || bf_cnt - b0 != NBF) begin
            errors++; $display("FAIL ignore_ops writes=%0d butterflies=%0d expected %0d", main_wr - w0, bf_cnt - b0, NBF);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ignore_busy got %b expected 0", busy);
        end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++; $display("FAIL ignore_ram[%0d] got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
        checks++;
        if (proto_err != p0) begin
            errors++; $display("FAIL ignore_proto start_without_ready=%0d expected 0", proto_err - p0);
        end
    endtask

    task automatic test_async_reset();
        int unsigned b0, w0, d0;
        bit got;
        bit to;
        m_lat_fixed = 30;
        load_ram(0);
        b0 = bf_cnt;
        got = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int unsigned c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bf_cnt != b0) begin got = 1'b1; break; end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (!got || busy !== 1'b1) begin
            errors++; $display("FAIL arst_pre started=%0d busy=%b expected 1/1", got, busy);
        end
        w0 = wr_cnt; d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, a_we, b_we, bf_start} !== 5'b0 || {a_addr, b_addr, bf_tw} !== '0) begin
            errors++; $display("FAIL arst_outputs ctrl=%b addr=%h expected 0/0",
                               {busy, done, a_we, b_we, bf_start}, {a_addr, b_addr, bf_tw});
        end
        checks++;
        if ({a_wdata, b_wdata, bf_r1, bf_i1, bf_r2, bf_i2} !== '0) begin
            errors++; $display("FAIL arst_data got nonzero data expected 0");
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (wr_cnt != w0 || done_cnt != d0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_quiet writes=%0d dones=%0d busy=%b expected 0/0/0",
                               wr_cnt - w0, done_cnt - d0, busy);
        end
        m_lat_fixed = 0;
        load_ram(0);
        ref_fft();
        run_fft(3000, to);
        checks++;
        if (to) begin errors++; $display("FAIL arst_restart_timeout no done within budget"); end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++; $display("FAIL arst_restart_ram[%0d] got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask

`ifdef FFT_BITREV_LOAD_EN
    task automatic test_bitrev();
        bit to;
        int exp_p [8];
        exp_p = '{0, 4, 2, 6, 1, 5, 3, 7};
        load_ram(2);
        ref_fft();
        run_fft(3000, to);
        checks++;
        if (to) begin errors++; $display("FAIL bitrev_timeout no done within budget"); end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (snap_mem[i] !== {32'(exp_p[i]), 32'h0}) begin
                errors++; $display("FAIL bitrev_perm[%0d] got %h expected %0d", i, snap_mem[i], exp_p[i]);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++; $display("FAIL bitrev_ram[%0d] got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_impulse();
        test_stale_valid();
        test_trace();
        test_start_ignored();
        test_async_reset();
`ifdef FFT_BITREV_LOAD_EN
        test_bitrev();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
